// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two dcaches, the coherence controller and the RAM.
// Index 0/1 selects the dcache; the RAM side is a single port.
interface coherence_bus_ctrl_if;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic             ram_ready;

  modport slave (
    input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// MSI snooping bus controller for two dcaches sharing one RAM port: arbitrates,
// snoops the other cache and serves each word from RAM or cache-to-cache.
module coherence_bus_ctrl (
  input  logic                 CLK,
  input  logic                 RST,
  coherence_bus_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, SNOOP, XFER0, XFER1, LOAD0, LOAD1, WB0, WB1, INV
  } state_e;

  state_e     state_q, state_d;
  logic       req_q, req_d;
  logic       last_q, last_d;
  logic       oth;
  logic       gnt;
  logic [1:0] reqv;

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    last_d           = last_q;
    oth              = ~req_q;
    reqv             = bus.dREN | bus.dWEN | bus.cctrans;
    gnt              = (reqv == 2'b11) ? ~last_q : ~reqv[0];
    bus.dwait        = 2'b11;
    bus.dload        = '0;
    bus.ccwait       = 2'b00;
    bus.ccinv        = 2'b00;
    bus.ccsnoopaddr  = '0;
    bus.ramREN       = 1'b0;
    bus.ramWEN       = 1'b0;
    bus.ramaddr      = '0;
    bus.ramstore     = '0;

    // Outputs are held at their idle values while reset is asserted so an
    // abandoned access can never produce a stray dwait pulse or RAM strobe.
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (|reqv) begin
            req_d  = gnt;
            last_d = gnt;
            if (bus.dWEN[gnt])
              state_d = WB0;
            else if (bus.dREN[gnt])
              state_d = SNOOP;
            else if (bus.ccwrite[gnt])
              state_d = INV;
          end
        end
        SNOOP: begin
          bus.ccwait[oth]      = 1'b1;
          bus.ccsnoopaddr[oth] = bus.daddr[req_q];
          bus.ccinv[oth]       = bus.ccwrite[req_q];
          state_d              = bus.cctrans[oth] ? XFER0 : LOAD0;
        end
        XFER0, XFER1: begin
          // Supplier's Modified data goes to the requester and to RAM at once.
          bus.ramWEN        = 1'b1;
          bus.ramaddr       = bus.daddr[oth];
          bus.ramstore      = bus.dstore[oth];
          bus.dload[req_q]  = bus.dstore[oth];
          bus.ccwait[oth]   = 1'b1;
          if (bus.ram_ready) begin
            bus.dwait = 2'b00;
            state_d   = (state_q == XFER0) ? XFER1 : IDLE;
          end
        end
        LOAD0, LOAD1: begin
          bus.ramREN        = 1'b1;
          bus.ramaddr       = bus.daddr[req_q];
          bus.dload[req_q]  = bus.ramload;
          bus.ccwait[oth]   = 1'b1;
          if (bus.ram_ready) begin
            bus.dwait[req_q] = 1'b0;
            state_d          = (state_q == LOAD0) ? LOAD1 : IDLE;
          end
        end
        WB0, WB1: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[req_q];
          bus.ramstore = bus.dstore[req_q];
          if (bus.ram_ready) begin
            bus.dwait[req_q] = 1'b0;
            state_d          = (state_q == WB0) ? WB1 : IDLE;
          end
        end
        INV: begin
          bus.ccwait[oth]      = 1'b1;
          bus.ccinv[oth]       = 1'b1;
          bus.ccsnoopaddr[oth] = bus.daddr[req_q];
          bus.dwait[req_q]     = 1'b0;
          state_d              = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // last resets to 1 so cache 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: word completions are checked against
// a scoreboard queue filled when each word's stimulus is driven.
module tb_coherence_bus_ctrl;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if bus ();

  coherence_bus_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [31:0] d);
    sb.push_back('{id: i[0], data: d});
  endtask

  // Waits (bounded) for dwait[i] low, then pops and compares the expected word.
  task automatic wait_word(input int i, input int budget);
    sb_t e;
    for (int n = 0; n < budget; n++) begin
      if (bus.dwait[i] === 1'b0) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("sb_id%0d", i), {31'd0, e.id}, i);
          chk($sformatf("dload%0d", i), bus.dload[i], e.data);
        end else begin
          chk("sb_underflow", sb.size(), 1);
        end
        return;
      end
      tick();
      settle();
    end
    chk($sformatf("dwait%0d_timeout", i), {31'd0, bus.dwait[i]}, 0);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic clear_inputs();
    bus.dREN      = '0;
    bus.dWEN      = '0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.cctrans   = '0;
    bus.ccwrite   = '0;
    bus.ramload   = '0;
    bus.ram_ready = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Entered at the IDLE sample point with dREN[i] high and daddr[i]=a already driven.
  task automatic read_xact(input int i, input logic [31:0] a, input logic inv,
                           input logic [31:0] w0, input logic [31:0] w1);
    tick(); settle();
    chk("snoop_addr", bus.ccsnoopaddr[1-i], a);
    chk("snoop_inv", {31'd0, bus.ccinv[1-i]}, {31'd0, inv});
    chk("snoop_ccwait", {31'd0, bus.ccwait[1-i]}, 1);
    chk("snoop_dwait", {30'd0, bus.dwait}, 3);
    tick();
    bus.ramload = w0;
    push_word(i, w0);
    settle();
    chk("load0_ren", {31'd0, bus.ramREN}, 1);
    chk("load0_addr", bus.ramaddr, a);
    chk("load0_other_dwait", {31'd0, bus.dwait[1-i]}, 1);
    wait_word(i, 1);
    tick();
    bus.daddr[i] = a + 32'd4;
    bus.ramload  = w1;
    push_word(i, w1);
    settle();
    chk("load1_addr", bus.ramaddr, a + 32'd4);
    wait_word(i, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    RST = 1'b1;
    clear_inputs();
    tick(); settle();
    chk("rst_dwait", {30'd0, bus.dwait}, 3);
    chk("rst_ramREN", {31'd0, bus.ramREN}, 0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 0);
    chk("rst_ccwait", {30'd0, bus.ccwait}, 0);
    chk("rst_dload0", bus.dload[0], 0);
    tick();
    RST = 1'b0;
    settle();
    chk("idle_dwait", {30'd0, bus.dwait}, 3);

    // Clean read miss from cache 0
    tick();
    bus.dREN[0]   = 1'b1;
    bus.daddr[0]  = 32'h100;
    bus.ram_ready = 1'b1;
    settle();
    chk("grant_dwait", {30'd0, bus.dwait}, 3);
    read_xact(0, 32'h100, 1'b0, 32'hAAAA0000, 32'hAAAA0004);
    tick();
    bus.dREN[0] = 1'b0;
    settle();
    chk("post_read_dwait", {30'd0, bus.dwait}, 3);
    chk("post_read_ccwait", {30'd0, bus.ccwait}, 0);

    // Modified supplier: cache 0 BusRdX, cache 1 supplies
    bus.dREN[0]    = 1'b1;
    bus.ccwrite[0] = 1'b1;
    bus.daddr[0]   = 32'h200;
    settle();
    tick();
    bus.cctrans[1] = 1'b1;
    bus.daddr[1]   = 32'h208;
    bus.dstore[1]  = 32'hDEAD0000;
    settle();
    chk("mod_snoop_inv", {31'd0, bus.ccinv[1]}, 1);
    chk("mod_snoop_addr", bus.ccsnoopaddr[1], 32'h200);
    tick();
    push_word(0, 32'hDEAD0000);
    settle();
    chk("xfer0_wen", {31'd0, bus.ramWEN}, 1);
    chk("xfer0_addr", bus.ramaddr, 32'h208);
    chk("xfer0_store", bus.ramstore, 32'hDEAD0000);
    chk("xfer0_dwait1", {31'd0, bus.dwait[1]}, 0);
    chk("xfer0_ccwait1", {31'd0, bus.ccwait[1]}, 1);
    wait_word(0, 1);
    tick();
    bus.daddr[0]  = 32'h204;
    bus.daddr[1]  = 32'h20C;
    bus.dstore[1] = 32'hDEAD0004;
    push_word(0, 32'hDEAD0004);
    settle();
    chk("xfer1_addr", bus.ramaddr, 32'h20C);
    chk("xfer1_dwait1", {31'd0, bus.dwait[1]}, 0);
    wait_word(0, 1);
    tick();
    clear_inputs();
    bus.ram_ready = 1'b1;
    settle();
    chk("post_xfer_dwait", {30'd0, bus.dwait}, 3);

    // Simultaneous requests after reset: 0, then 1, then 0 again
    do_reset();
    bus.dREN      = 2'b11;
    bus.daddr[0]  = 32'h500;
    bus.daddr[1]  = 32'h600;
    bus.ram_ready = 1'b1;
    settle();
    read_xact(0, 32'h500, 1'b0, 32'h11110000, 32'h11110004);
    tick();
    bus.daddr[0] = 32'h540;
    settle();
    read_xact(1, 32'h600, 1'b0, 32'h22220000, 32'h22220004);
    tick();
    bus.daddr[1] = 32'h640;
    settle();
    read_xact(0, 32'h540, 1'b0, 32'h33330000, 32'h33330004);
    tick();
    bus.dREN = 2'b00;
    settle();
    chk("post_tie_dwait", {30'd0, bus.dwait}, 3);

    // Upgrade from cache 1
    bus.cctrans[1] = 1'b1;
    bus.ccwrite[1] = 1'b1;
    bus.daddr[1]   = 32'h300;
    settle();
    tick();
    push_word(1, 32'h0);
    settle();
    chk("inv_ccinv0", {31'd0, bus.ccinv[0]}, 1);
    chk("inv_snoop0", bus.ccsnoopaddr[0], 32'h300);
    chk("inv_ccwait0", {31'd0, bus.ccwait[0]}, 1);
    chk("inv_dwait0", {31'd0, bus.dwait[0]}, 1);
    wait_word(1, 1);
    tick();
    bus.cctrans[1] = 1'b0;
    bus.ccwrite[1] = 1'b0;
    settle();
    chk("post_inv_dwait", {30'd0, bus.dwait}, 3);
    chk("post_inv_ccinv", {30'd0, bus.ccinv}, 0);

    // Writeback from cache 0 with slow RAM
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h400;
    bus.dstore[0] = 32'hCAFE0000;
    bus.ram_ready = 1'b0;
    settle();
    for (int w = 0; w < 2; w++) begin
      tick();
      if (w == 1) begin
        bus.daddr[0]  = 32'h404;
        bus.dstore[0] = 32'hCAFE0004;
        bus.ram_ready = 1'b0;
      end
      settle();
      for (int k = 0; k < 3; k++) begin
        chk("wb_dwait_hold", {31'd0, bus.dwait[0]}, 1);
        chk("wb_ccwait1", {31'd0, bus.ccwait[1]}, 0);
        chk("wb_wen", {31'd0, bus.ramWEN}, 1);
        tick(); settle();
      end
      bus.ram_ready = 1'b1;
      push_word(0, 32'h0);
      settle();
      chk("wb_addr", bus.ramaddr, (w == 0) ? 32'h400 : 32'h404);
      chk("wb_store", bus.ramstore, (w == 0) ? 32'hCAFE0000 : 32'hCAFE0004);
      chk("wb_ccwait1_done", {31'd0, bus.ccwait[1]}, 0);
      wait_word(0, 1);
    end
    tick();
    bus.dWEN[0] = 1'b0;
    settle();
    chk("post_wb_dwait", {30'd0, bus.dwait}, 3);

    // Reset during LOAD1 of a cache 1 read
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h700;
    settle();
    tick(); settle();
    tick();
    bus.ramload = 32'h77770000;
    push_word(1, 32'h77770000);
    settle();
    wait_word(1, 1);
    tick();
    bus.daddr[1] = 32'h704;
    RST = 1'b1;
    settle();
    chk("rstmid_dwait", {30'd0, bus.dwait}, 3);
    chk("rstmid_ramREN", {31'd0, bus.ramREN}, 0);
    tick();
    RST = 1'b0;
    bus.dREN[1] = 1'b0;
    settle();
    chk("after_rst_dwait", {30'd0, bus.dwait}, 3);
    chk("after_rst_ramREN", {31'd0, bus.ramREN}, 0);
    chk("after_rst_ccwait", {30'd0, bus.ccwait}, 0);
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h800;
    settle();
    read_xact(0, 32'h800, 1'b0, 32'h88880000, 32'h88880004);
    tick();
    bus.dREN[0] = 1'b0;
    settle();
    chk("final_dwait", {30'd0, bus.dwait}, 3);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Memory-side responder for the two dcache control units: it arbitrates their bus requests (dREN/dWEN/daddr/dstore/ccwrite/cctrans), runs the MSI snoop, and serves each word from RAM or from the other cache. It sits between both dcaches and the single-port RAM, in place of the plain memory controller. Blocks are two words; the requesting dcache sequences the two word addresses itself.

## Interface
- Parameters: none. The two-cache configuration is fixed; index i ∈ {0,1}, and "other" means 1-i.
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- dREN[i], dWEN[i]  in  1 each  read / write word request from dcache i
- daddr[i], dstore[i]  in  32 each  word address and write data from dcache i
- cctrans[i]  in  1 each  coherence transaction flag; as a snoop response, "I hold the line Modified and will supply it"
- ccwrite[i]  in  1 each  exclusive intent (BusRdX or upgrade)
- dwait[i]  out  1 each  stall; 0 for exactly the cycle a word completes
- dload[i]  out  32 each  read data to dcache i
- ccwait[i]  out  1 each  dcache i is being snooped or held
- ccinv[i]  out  1 each  invalidate the snooped line in dcache i
- ccsnoopaddr[i]  out  32 each  snoop address to dcache i
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr, ramstore  out  32  RAM address and write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM completes the current access this cycle

## Operation
- States: IDLE, SNOOP, XFER0, XFER1, LOAD0, LOAD1, WB0, WB1, INV. Registers: state, req (granted cache id), last (last granted id).
- Request from cache i: dREN[i] | dWEN[i] | cctrans[i].
- IDLE, arbitration:
  - If both caches request, grant 1-last.
  - Otherwise grant the single requester.
  - On a grant: req ← i, last ← i.
  - Next state: dWEN[i] → WB0; dREN[i] → SNOOP; cctrans[i] & ccwrite[i] with no dREN/dWEN → INV.
- SNOOP, one cycle:
  - ccwait[other]=1, ccsnoopaddr[other]=daddr[req], ccinv[other]=ccwrite[req].
  - Sample cctrans[other] this cycle: 1 → XFER0, 0 → LOAD0.
- XFER0 / XFER1, cache-to-cache transfer with memory update:
  - ramWEN=1, ramaddr=daddr[other], ramstore=dstore[other].
  - dload[req]=dstore[other]; ccwait[other]=1.
  - On ram_ready: dwait[req]=0 and dwait[other]=0 in the same cycle; XFER0→XFER1, XFER1→IDLE.
- LOAD0 / LOAD1:
  - ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - On ram_ready: dwait[req]=0; LOAD0→LOAD1, LOAD1→IDLE.
- WB0 / WB1:
  - ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req].
  - On ram_ready: dwait[req]=0; WB0→WB1, WB1→IDLE.
  - No snoop is done on writeback.
- INV, one cycle:
  - ccwait[other]=1, ccinv[other]=1, ccsnoopaddr[other]=daddr[req].
  - dwait[req]=0; next state IDLE.
- ccwait[other] stays asserted for every state of a granted transaction except IDLE and WB*.
- Default output values in any state not listed above: dwait=1, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, all RAM outputs 0.

## Timing
- Reset: state=IDLE, last=1 (so cache 0 wins the first tie), req=0; all outputs at default values (dwait=2'b11).
- Reset mid-transaction: IDLE on the next edge, any RAM access abandoned, no dwait pulse.
- State, req and last are registered. All outputs are combinational from state, req, the dcache inputs and ram_ready.
- Grant latency: 1 cycle (the IDLE cycle).
- Read miss latency, no supplier: 1 (IDLE) + 1 (SNOOP) + RAM latency per word.
- With ram_ready tied high:
  - LOAD0 completes in cycle 3 after the request appears, LOAD1 in cycle 4.
  - A writeback completes in cycles 2 and 3.
- Requests that arrive while state ≠ IDLE wait; they are never dropped. The dcache holds its request until it sees dwait=0.
- A request is sampled only in IDLE. A request that drops before it is granted is ignored.
- Second-word sequencing: the requester changes daddr between words. The block uses daddr as it is during each word state.
- No bus error is modelled. RAM inputs are ignored in IDLE, SNOOP and INV.

## Test plan
- Clean read miss:
  - Stimulus: cache0 dREN=1, daddr=0x100, then 0x104; cache1 answers cctrans=0; RAM returns 0xAAAA0000, 0xAAAA0004 with ram_ready=1.
  - Required: ccsnoopaddr[1]=0x100 and ccinv[1]=0 in SNOOP; dload[0] equals each RAM word with dwait[0]=0 on cycles 3 and 4.
- Modified supplier:
  - Stimulus: cache0 BusRdX (ccwrite=1) at 0x200; cache1 asserts cctrans=1 and drives dstore=0xDEAD0000, 0xDEAD0004.
  - Required: ccinv[1]=1 in SNOOP; ramWEN=1 with ramaddr=daddr[1]; dload[0]=0xDEAD0000, then 0xDEAD0004; dwait[0]=dwait[1]=0 on each ram_ready.
- Simultaneous requests:
  - Stimulus: both caches request read misses in the same cycle, with last=1 after reset.
  - Required: cache0 is served first, cache1 next; a third tie then grants cache0 again, because last alternates.
- Upgrade:
  - Stimulus: cache1 cctrans=1, ccwrite=1, dREN=dWEN=0, daddr=0x300.
  - Required: one INV cycle with ccinv[0]=1 and ccsnoopaddr[0]=0x300, dwait[1]=0 in that cycle, then IDLE.
- Writeback with slow RAM:
  - Stimulus: cache0 dWEN, daddr=0x400, 0x404; ram_ready low for 3 cycles per word.
  - Required: dwait[0] held at 1 until each ram_ready; ramstore equals dstore[0]; ccwait[1]=0 throughout.
- Reset mid-op:
  - Stimulus: assert RST during LOAD1.
  - Required: next cycle state=IDLE, dwait=2'b11, ramREN=0; a request issued after reset is granted normally.
